// File: rtl/rf_operand_fetch_pkg.sv
// Shared widths and the writeback record used by the
// operand-fetch front end and its bypass selectors.
package rf_operand_fetch_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_t;

endpackage

// File: rtl/rf_bypass_sel.sv
// Per-operand source select: zero register, then the
// in-flight writebacks newest first, then array data.
module rf_bypass_sel
   import rf_operand_fetch_pkg::*;
(
   input  logic [ADDR_W-1:0] idx,
   input  wb_t               live,
   input  wb_t               wb_q,
   input  wb_t               sn_q,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] data
);

   always_comb begin
      data = rf_data;
      if (idx == REG_ZERO)
         data = '0;
      else if (live.valid && live.addr == idx)
         data = live.data;
      else if (wb_q.valid && wb_q.addr == idx)
         data = wb_q.data;
      else if (sn_q.valid && sn_q.addr == idx)
         data = sn_q.data;
   end

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch / writeback front end for a 2R1W register
// file with 1-cycle read and three-deep write forwarding.
module rf_operand_fetch #(
   parameter int DATA_W = rf_operand_fetch_pkg::DATA_W,
   parameter int ADDR_W = rf_operand_fetch_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_rs1,
   input  logic [ADDR_W-1:0] req_rs2,
   input  logic [ADDR_W-1:0] req_rd,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [ADDR_W-1:0] op_rd,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic [ADDR_W-1:0] rf_addr_a,
   output logic [ADDR_W-1:0] rf_addr_b,
   input  logic [DATA_W-1:0] rf_data_a,
   input  logic [DATA_W-1:0] rf_data_b,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr_wr,
   output logic [DATA_W-1:0] rf_data_in
);

   import rf_operand_fetch_pkg::wb_t;
   import rf_operand_fetch_pkg::REG_ZERO;

   wb_t live;
   wb_t wb_q;
   wb_t sn_q;

   logic              r_valid;
   logic [ADDR_W-1:0] r_rs1;
   logic [ADDR_W-1:0] r_rs2;
   logic [ADDR_W-1:0] r_rd;

   logic              stall;
   logic              r_hold;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;

   assign live = '{valid: wb_valid && (wb_addr != REG_ZERO),
                   addr:  wb_addr,
                   data:  wb_data};

   assign stall     = op_valid && !op_ready;
   assign r_hold    = r_valid && stall;
   assign req_ready = !r_hold;

   // A held R re-reads its own sources so rf_data stays current
   assign rf_addr_a = r_hold ? r_rs1 : req_rs1;
   assign rf_addr_b = r_hold ? r_rs2 : req_rs2;

   assign rf_we      = wb_q.valid;
   assign rf_addr_wr = wb_q.addr;
   assign rf_data_in = wb_q.data;

   // SN holds the write the array commits at the edge R sampled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_q <= '0;
         sn_q <= '0;
      end else begin
         wb_q <= live.valid ? live : '0;
         sn_q <= wb_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
      end else if (!r_hold) begin
         r_valid <= req_valid;
         r_rs1   <= req_rs1;
         r_rs2   <= req_rs2;
         r_rd    <= req_rd;
      end
   end

   rf_bypass_sel u_sel_a (
      .idx     (r_rs1),
      .live    (live),
      .wb_q    (wb_q),
      .sn_q    (sn_q),
      .rf_data (rf_data_a),
      .data    (sel_a)
   );

   rf_bypass_sel u_sel_b (
      .idx     (r_rs2),
      .live    (live),
      .wb_q    (wb_q),
      .sn_q    (sn_q),
      .rf_data (rf_data_b),
      .data    (sel_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_rd    <= '0;
      end else if (r_valid && !stall) begin
         op_valid <= 1'b1;
         op_a     <= sel_a;
         op_b     <= sel_b;
         op_rd    <= r_rd;
      end else if (op_ready) begin
         op_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Scoreboard bench for rf_operand_fetch with an external
// register-file model and an architectural-state reference.
module tb_rf_operand_fetch;

   localparam int DW = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_rs1 = '0;
   logic [AW-1:0] req_rs2 = '0;
   logic [AW-1:0] req_rd = '0;
   logic          op_valid;
   logic          op_ready = 1'b1;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [AW-1:0] op_rd;
   logic          wb_valid = 1'b0;
   logic [AW-1:0] wb_addr = '0;
   logic [DW-1:0] wb_data = '0;
   logic [AW-1:0] rf_addr_a;
   logic [AW-1:0] rf_addr_b;
   logic [DW-1:0] rf_data_a = '0;
   logic [DW-1:0] rf_data_b = '0;
   logic          rf_we;
   logic [AW-1:0] rf_addr_wr;
   logic [DW-1:0] rf_data_in;

   rf_operand_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_rd     (req_rd),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_rd      (op_rd),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .rf_addr_a  (rf_addr_a),
      .rf_addr_b  (rf_addr_b),
      .rf_data_a  (rf_data_a),
      .rf_data_b  (rf_data_b),
      .rf_we      (rf_we),
      .rf_addr_wr (rf_addr_wr),
      .rf_data_in (rf_data_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // register file: synchronous read, read-before-write, r0 = 0
   logic [DW-1:0] mem [256] = '{default: '0};
   always @(posedge clk) begin
      rf_data_a <= (rf_addr_a == '0) ? '0 : mem[rf_addr_a];
      rf_data_b <= (rf_addr_b == '0) ? '0 : mem[rf_addr_b];
      if (rf_we && rf_addr_wr != '0) mem[rf_addr_wr] <= rf_data_in;
   end

   typedef struct {
      int            acc;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic [AW-1:0] rd;
   } req_t;

   typedef struct {
      int            cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   req_t          exp_q [$];
   wr_t           wlog [$];
   logic [DW-1:0] base [256] = '{default: '0};
   int            n_vec = 0;
   int            n_err = 0;
   logic          accepted = 1'b0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // value a register holds once all writebacks up to cycle upto land
   function automatic logic [DW-1:0] arch(logic [AW-1:0] a, int upto);
      if (a == '0) return '0;
      for (int i = wlog.size() - 1; i >= 0; i--)
         if (wlog[i].addr == a && wlog[i].cyc <= upto)
            return wlog[i].data;
      return base[a];
   endfunction

   // monitor: records issue/writebacks, checks outputs
   initial begin
      logic          held;
      logic          st1;
      logic          st2;
      logic          has_cur;
      logic          pw_v;
      logic [AW-1:0] pw_a;
      logic [DW-1:0] pw_d;
      logic [DW-1:0] ea;
      logic [DW-1:0] eb;
      req_t          cur;
      held = 0; st1 = 0; st2 = 0; has_cur = 0;
      pw_v = 0; pw_a = '0; pw_d = '0; ea = '0; eb = '0;
      cur = '{0, '0, '0, '0};
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            wlog.delete();
            foreach (base[i]) base[i] = mem[i];
            held = 0; st1 = 0; st2 = 0; has_cur = 0;
            pw_v = 0; accepted = 0;
         end else begin
            chk("rf_we", 64'(rf_we), 64'(pw_v));
            if (pw_v) begin
               chk("rf_addr_wr", 64'(rf_addr_wr), 64'(pw_a));
               chk("rf_data_in", 64'(rf_data_in), 64'(pw_d));
            end
            accepted = req_valid && req_ready;
            if (accepted)
               exp_q.push_back('{cyc, req_rs1, req_rs2, req_rd});
            pw_v = wb_valid && wb_addr != '0;
            pw_a = wb_addr;
            pw_d = wb_data;
            if (pw_v) wlog.push_back('{cyc, wb_addr, wb_data});
            if (op_valid) begin
               if (!held) begin
                  if (exp_q.size() == 0) begin
                     chk("spurious_op_valid", 64'(op_valid), 64'(0));
                     has_cur = 0;
                  end else begin
                     cur = exp_q.pop_front();
                     has_cur = 1;
                     ea = arch(cur.rs1, cyc - 1);
                     eb = arch(cur.rs2, cyc - 1);
                     if (!st1 && !st2)
                        chk("latency", 64'(cyc), 64'(cur.acc + 2));
                  end
               end
               if (has_cur) begin
                  chk("op_a", 64'(op_a), 64'(ea));
                  chk("op_b", 64'(op_b), 64'(eb));
                  chk("op_rd", 64'(op_rd), 64'(cur.rd));
               end
            end
            st2 = st1;
            st1 = op_valid && !op_ready;
            held = st1;
         end
      end
   end

   task automatic drive(bit rv, logic [AW-1:0] rs1, logic [AW-1:0] rs2,
                        logic [AW-1:0] rd, bit wv, logic [AW-1:0] wa,
                        logic [DW-1:0] wd, bit ordy);
      @(posedge clk);
      #1;
      req_valid = rv;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_rd    = rd;
      wb_valid  = wv;
      wb_addr   = wa;
      wb_data   = wd;
      op_ready  = ordy;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_op_valid"}, 64'(op_valid), 64'(0));
      chk({tag, "_op_a"}, 64'(op_a), 64'(0));
      chk({tag, "_op_b"}, 64'(op_b), 64'(0));
      chk({tag, "_op_rd"}, 64'(op_rd), 64'(0));
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
      chk({tag, "_rf_we"}, 64'(rf_we), 64'(0));
      chk({tag, "_rf_addr_wr"}, 64'(rf_addr_wr), 64'(0));
      chk({tag, "_rf_data_in"}, 64'(rf_data_in), 64'(0));
   endtask

   initial begin
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;

      // write then later read back through the array
      drive(0, 0, 0, 0, 1, 5, 32'h11, 1);
      idle(3);
      drive(1, 5, 6, 1, 0, 0, 0, 1);
      idle(3);

      // requests straddling a writeback to r7
      drive(1, 7, 0, 2, 0, 0, 0, 1);
      drive(1, 7, 0, 2, 0, 0, 0, 1);
      drive(1, 7, 0, 2, 1, 7, 32'hAA, 1);
      drive(1, 7, 0, 2, 0, 0, 0, 1);
      drive(1, 7, 7, 2, 0, 0, 0, 1);
      idle(3);

      // r0 never written, never forwarded
      drive(1, 0, 0, 3, 1, 0, 32'hFF, 1);
      idle(3);

      // five cycles of backpressure with a write to the held source
      drive(1, 1, 2, 4, 0, 0, 0, 0);
      drive(1, 5, 3, 5, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 3, 32'h33, 0);
      chk("req_ready_stall", 64'(req_ready), 64'(0));
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);

      // back-to-back writes to r9, newer must win
      drive(0, 0, 0, 0, 1, 9, 32'h1, 1);
      drive(1, 9, 9, 6, 1, 9, 32'h2, 1);
      idle(3);

      // randomized traffic over a small register window
      for (int i = 0; i < 800; i++) begin
         @(posedge clk);
         #1;
         if (!req_valid || accepted) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_rs1   = AW'($urandom_range(0, 7));
            req_rs2   = AW'($urandom_range(0, 7));
            req_rd    = AW'($urandom_range(0, 255));
         end
         wb_valid = 1'($urandom_range(0, 1));
         wb_addr  = AW'($urandom_range(0, 7));
         wb_data  = $urandom;
         op_ready = ($urandom_range(0, 3) != 0);
      end
      idle(10);
      chk("drain", 64'(exp_q.size()), 64'(0));

      // reset while an output and a writeback are in flight
      drive(1, 2, 3, 4, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1, 12, 32'hC0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_op_valid", 64'(op_valid), 64'(1));
      chk("pre_rst_rf_we", 64'(rf_we), 64'(1));
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      op_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1);
         chk("post_rst_op_valid", 64'(op_valid), 64'(0));
      end

      // the write lost at reset must not appear
      drive(1, 12, 3, 7, 0, 0, 0, 1);
      idle(5);
      chk("final_drain", 64'(exp_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
